// File: rtl/hilo_div_collector_pkg.sv
// Shared constants for the HI/LO divide collector: divider latency, HI/LO select
// indices and the per-cycle divide event encoding.
package hilo_div_collector_pkg;

  localparam int DIV_LATENCY = 17;

  localparam int HILO_SEL_HI = 1;
  localparam int HILO_SEL_LO = 0;

  localparam logic [1:0] HILO_RD_HI = 2'b10;
  localparam logic [1:0] HILO_RD_LO = 2'b01;

  typedef enum logic [1:0] {
    CNT_HOLD  = 2'b00,
    CNT_DONE  = 2'b01,
    CNT_ISSUE = 2'b10,
    CNT_BOTH  = 2'b11
  } cnt_ev_e;

endpackage

// File: rtl/hilo_div_collector_hilo_regfile.sv
// HI/LO register pair: divide capture beats MT writes, and the read mux forwards
// the completing divide result in its done cycle.
module hilo_regfile
  import hilo_div_collector_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cap_en_i,
  input  logic [DATA_W-1:0] quotient_i,
  input  logic [DATA_W-1:0] remainder_i,
  input  logic              mt_en_i,
  input  logic [1:0]        hilo_wr_i,
  input  logic [DATA_W-1:0] hilo_wdata_i,
  input  logic              fwd_en_i,
  input  logic [1:0]        hilo_rd_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  // Next HI/LO: a captured divide result overrides any MT write on the same edge
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (cap_en_i) begin
      hi_d = remainder_i;
      lo_d = quotient_i;
    end else if (mt_en_i) begin
      if (hilo_wr_i[HILO_SEL_HI]) begin
        hi_d = hilo_wdata_i;
      end else begin
        hi_d = hi_q;
      end
      if (hilo_wr_i[HILO_SEL_LO]) begin
        lo_d = hilo_wdata_i;
      end else begin
        lo_d = lo_q;
      end
    end else begin
      hi_d = hi_q;
      lo_d = lo_q;
    end
  end

  // HI/LO state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Read mux with zero-latency forwarding of the completing divide
  always_comb begin
    rdata_o = '0;
    case (hilo_rd_i)
      HILO_RD_HI: rdata_o = fwd_en_i ? remainder_i : hi_q;
      HILO_RD_LO: rdata_o = fwd_en_i ? quotient_i  : lo_q;
      default:    rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/hilo_div_collector.sv
// Divider consumer: tracks divides in flight, captures results into HI/LO and
// interlocks HI/LO accesses until the last outstanding divide completes.
module hilo_div_collector
  import hilo_div_collector_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DIV_LAT = DIV_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              div_issue,
  input  logic              div_done,
  input  logic [DATA_W-1:0] quotient,
  input  logic [DATA_W-1:0] remainder,
  input  logic [1:0]        hilo_wr,
  input  logic [DATA_W-1:0] hilo_wdata,
  input  logic [1:0]        hilo_rd,
  output logic [DATA_W-1:0] hilo_rdata,
  output logic              stall_req,
  output logic              div_busy,
  output logic              ovf_err
);

  localparam int               CNT_W   = $clog2(DIV_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_eff_s;
  logic             cnt_err_s;
  logic             collision_s;
  logic             cap_en_s;
  logic             mt_en_s;

  // Count as seen after this cycle's completion; saturates so a stray done cannot wrap
  always_comb begin
    count_eff_s = count_q;
    if (div_done && (count_q != '0)) begin
      count_eff_s = count_q - CNT_ONE;
    end else begin
      count_eff_s = count_q;
    end
  end

  // Interlock is independent of stall to keep the hazard unit free of loops
  always_comb begin
    stall_req   = ((|hilo_rd) | (|hilo_wr)) & (count_eff_s != '0);
    cap_en_s    = div_done & ~stall & ~flush;
    mt_en_s     = ~stall & ~stall_req & ~flush;
    collision_s = div_done & (|hilo_wr) & ~stall_req;
  end

  // In-flight counter and sticky error next state
  always_comb begin
    count_d   = count_q;
    cnt_err_s = 1'b0;
    if (flush) begin
      count_d = '0;
    end else if (!stall) begin
      case (cnt_ev_e'({div_issue, div_done}))
        CNT_ISSUE: begin
          if (count_q == CNT_MAX) cnt_err_s = 1'b1;
          else                    count_d   = count_q + CNT_ONE;
        end
        CNT_DONE: begin
          if (count_q == '0) cnt_err_s = 1'b1;
          else               count_d   = count_q - CNT_ONE;
        end
        default: count_d = count_q;
      endcase
    end else begin
      count_d = count_q;
    end
    ovf_d = ovf_q | (~flush & ~stall & (cnt_err_s | collision_s));
  end

  // Counter and error state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    div_busy = (count_q != '0);
    ovf_err  = ovf_q;
  end

  hilo_regfile #(
    .DATA_W(DATA_W)
  ) u_regfile (
    .clk_i       (clk),
    .rst_ni      (reset),
    .cap_en_i    (cap_en_s),
    .quotient_i  (quotient),
    .remainder_i (remainder),
    .mt_en_i     (mt_en_s),
    .hilo_wr_i   (hilo_wr),
    .hilo_wdata_i(hilo_wdata),
    .fwd_en_i    (div_done),
    .hilo_rd_i   (hilo_rd),
    .rdata_o     (hilo_rdata)
  );

endmodule

// File: tb/tb_hilo_div_collector.sv
// Bench for hilo_div_collector: directed scenarios plus random traffic checked
// each cycle against a behavioural model of counter, HI/LO and interlock.
module tb_hilo_div_collector;

  localparam int W   = 32;
  localparam int LAT = 17;

  logic         clk = 1'b0;
  logic         reset;
  logic         stall, flush, div_issue, div_done;
  logic [W-1:0] quotient, remainder, hilo_wdata, hilo_rdata;
  logic [1:0]   hilo_wr, hilo_rd;
  logic         stall_req, div_busy, ovf_err;

  int n_checks = 0;
  int n_fail   = 0;

  int         m_cnt;
  logic [W-1:0] m_hi, m_lo;
  bit         m_ovf;

  always #5 clk = ~clk;

  hilo_div_collector #(.DATA_W(W), .DIV_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .div_issue(div_issue), .div_done(div_done),
    .quotient(quotient), .remainder(remainder),
    .hilo_wr(hilo_wr), .hilo_wdata(hilo_wdata), .hilo_rd(hilo_rd),
    .hilo_rdata(hilo_rdata), .stall_req(stall_req),
    .div_busy(div_busy), .ovf_err(ovf_err)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_sreq();
    int eff;
    eff = m_cnt - (div_done ? 1 : 0);
    if (eff < 0) eff = 0;
    return ((hilo_rd != 2'b00) || (hilo_wr != 2'b00)) && (eff != 0);
  endfunction

  function automatic logic [W-1:0] exp_rdata();
    if (hilo_rd == 2'b10) return div_done ? remainder : m_hi;
    if (hilo_rd == 2'b01) return div_done ? quotient  : m_lo;
    return '0;
  endfunction

  task automatic model_update();
    bit sreq;
    sreq = exp_sreq();
    if (flush) begin
      m_cnt = 0;
    end else if (!stall) begin
      if (div_done) begin
        m_lo = quotient;
        m_hi = remainder;
        if (hilo_wr != 2'b00 && !sreq) m_ovf = 1'b1;
      end else if (!sreq) begin
        if (hilo_wr[1]) m_hi = hilo_wdata;
        if (hilo_wr[0]) m_lo = hilo_wdata;
      end
      if (div_issue && !div_done) begin
        if (m_cnt == LAT) m_ovf = 1'b1;
        else              m_cnt++;
      end
      if (div_done && !div_issue) begin
        if (m_cnt == 0) m_ovf = 1'b1;
        else            m_cnt--;
      end
    end
  endtask

  task automatic idle();
    stall = 1'b0; flush = 1'b0; div_issue = 1'b0; div_done = 1'b0;
    quotient = '0; remainder = '0; hilo_wr = 2'b00; hilo_wdata = '0; hilo_rd = 2'b00;
  endtask

  // One clock: compare outputs against the model mid-cycle, then advance the model
  task automatic step();
    @(negedge clk);
    check("rdata",     hilo_rdata,       exp_rdata());
    check("stall_req", 32'(stall_req),   32'(exp_sreq()));
    check("div_busy",  32'(div_busy),    32'(m_cnt != 0));
    check("ovf_err",   32'(ovf_err),     32'(m_ovf));
    model_update();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset applied away from any clock edge, then released
  task automatic do_reset();
    reset = 1'b0;
    m_cnt = 0; m_hi = '0; m_lo = '0; m_ovf = 1'b0;
    #1;
    check("rst_busy", 32'(div_busy),  32'd0);
    check("rst_sreq", 32'(stall_req), 32'd0);
    check("rst_ovf",  32'(ovf_err),   32'd0);
    check("rst_rdata", hilo_rdata,    (hilo_rd == 2'b00 || div_done) ? exp_rdata() : 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    m_cnt = 0; m_hi = '0; m_lo = '0; m_ovf = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Reset mid-operation
    div_issue = 1'b1;
    repeat (4) step();
    check("t1_busy_pre", 32'(div_busy), 32'd1);
    div_issue = 1'b0; hilo_rd = 2'b10;
    #3;
    do_reset();
    hilo_rd = 2'b10; #1;
    check("t1_hi_zero", hilo_rdata, 32'd0);
    hilo_rd = 2'b01; #1;
    check("t1_lo_zero", hilo_rdata, 32'd0);
    idle();

    // Single divide 100/7 with mflo in the done cycle
    div_issue = 1'b1; step(); div_issue = 1'b0;
    repeat (16) step();
    div_done = 1'b1; quotient = 32'd14; remainder = 32'd2; hilo_rd = 2'b01; #1;
    check("t2_fwd_lo", hilo_rdata, 32'd14);
    check("t2_sreq",   32'(stall_req), 32'd0);
    step();
    idle(); hilo_rd = 2'b01; #1;
    check("t2_lo", hilo_rdata, 32'd14);
    hilo_rd = 2'b10; #1;
    check("t2_hi", hilo_rdata, 32'd2);
    step(); idle();

    // Three divides in flight, mfhi interlocked until the third completes
    div_issue = 1'b1; repeat (3) step(); div_issue = 1'b0;
    hilo_rd = 2'b10; #1;
    check("t3_sreq_wait", 32'(stall_req), 32'd1);
    step();
    div_done = 1'b1; quotient = 32'd50; remainder = 32'd5; #1;
    check("t3_sreq_d1", 32'(stall_req), 32'd1);
    step();
    div_done = 1'b0; step();
    div_done = 1'b1; quotient = 32'd60; remainder = 32'd6; step();
    div_done = 1'b1; quotient = 32'd70; remainder = 32'd7; #1;
    check("t3_sreq_d3", 32'(stall_req), 32'd0);
    check("t3_fwd_hi",  hilo_rdata,     32'd7);
    step();
    div_done = 1'b0; #1;
    check("t3_hi", hilo_rdata, 32'd7);
    step(); idle();

    // Flush with two in flight, then mtlo
    div_issue = 1'b1; repeat (2) step(); div_issue = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    check("t4_busy", 32'(div_busy), 32'd0);
    hilo_rd = 2'b10; #1;
    check("t4_hi_kept", hilo_rdata, 32'd7);
    hilo_rd = 2'b00; hilo_wr = 2'b01; hilo_wdata = 32'hDEAD; step();
    hilo_wr = 2'b00; hilo_rd = 2'b01; #1;
    check("t4_lo", hilo_rdata, 32'hDEAD);
    step(); idle();

    // Stall held across a done: exactly one capture and decrement
    div_issue = 1'b1; step(); div_issue = 1'b0; step();
    stall = 1'b1; div_done = 1'b1; quotient = 32'h55; remainder = 32'h66;
    for (int i = 0; i < 4; i++) begin
      check("t5_busy_stall", 32'(div_busy), 32'd1);
      step();
    end
    stall = 1'b0; step();
    div_done = 1'b0; hilo_rd = 2'b01; #1;
    check("t5_busy_after", 32'(div_busy), 32'd0);
    check("t5_lo", hilo_rdata, 32'h55);
    step(); idle();

    // Done with nothing in flight; issue+done together
    check("t6_ovf_pre", 32'(ovf_err), 32'd0);
    div_done = 1'b1; quotient = 32'h11; remainder = 32'h22; step(); div_done = 1'b0;
    check("t6_ovf", 32'(ovf_err), 32'd1);
    div_issue = 1'b1; step();
    div_done = 1'b1; step();
    div_issue = 1'b0; div_done = 1'b0;
    check("t6_busy_both", 32'(div_busy), 32'd1);
    div_done = 1'b1; step(); div_done = 1'b0;
    check("t6_busy_end", 32'(div_busy), 32'd0);
    check("t6_ovf_sticky", 32'(ovf_err), 32'd1);
    do_reset();

    // Counter saturation at DIV_LAT
    div_issue = 1'b1; repeat (LAT) step();
    check("sat_ovf_pre", 32'(ovf_err), 32'd0);
    step(); div_issue = 1'b0;
    check("sat_ovf", 32'(ovf_err), 32'd1);
    div_done = 1'b1; repeat (LAT - 1) step();
    check("sat_busy_last", 32'(div_busy), 32'd1);
    step(); div_done = 1'b0;
    check("sat_busy_end", 32'(div_busy), 32'd0);
    do_reset();

    // Divide capture colliding with mthi in the last completion cycle
    div_issue = 1'b1; step(); div_issue = 1'b0;
    div_done = 1'b1; quotient = 32'h1234; remainder = 32'h5678;
    hilo_wr = 2'b10; hilo_wdata = 32'hBEEF; step(); idle();
    hilo_rd = 2'b10; #1;
    check("col_hi", hilo_rdata, 32'h5678);
    check("col_ovf", 32'(ovf_err), 32'd1);
    step(); idle();
    do_reset();

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      idle();
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        continue;
      end
      stall      = ($urandom_range(0, 7) == 0);
      flush      = ($urandom_range(0, 39) == 0);
      div_issue  = ($urandom_range(0, 3) == 0);
      div_done   = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
      if (div_issue && !div_done && m_cnt == 0 && $urandom_range(0, 1) == 0) div_issue = 1'b0;
      quotient   = $urandom;
      remainder  = $urandom;
      hilo_wr    = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      hilo_wdata = $urandom;
      case ($urandom_range(0, 3))
        0:       hilo_rd = 2'b01;
        1:       hilo_rd = 2'b10;
        default: hilo_rd = 2'b00;
      endcase
      step();
    end

    idle();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
